// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : State encoding, owner codes and helpers shared by the
//               fetch/data memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_BUSY_I = ST_BUSY_I,
    S_BUSY_D = ST_BUSY_D
  } state_e;

  // Codes presented on the owner output
  localparam logic [1:0] OWNER_IDLE  = 2'b00;
  localparam logic [1:0] OWNER_FETCH = 2'b01;
  localparam logic [1:0] OWNER_DATA  = 2'b10;

  // Map an arbiter state onto the externally visible owner code
  function automatic logic [1:0] owner_of(input state_e s);
    logic [1:0] code;
    code = OWNER_IDLE;
    case (s)
      S_BUSY_I: code = OWNER_FETCH;
      S_BUSY_D: code = OWNER_DATA;
      default:  code = OWNER_IDLE;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data and memory req/ack handshake bundle around the
//               shared memory-port arbiter.
//               master : arbiter view.  slave : pipeline + memory view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  // Fetch port
  logic                       if_req;
  logic [ADDRESS_WIDTH-1:0]   if_addr;
  logic                       if_ack;
  logic [DATA_WIDTH-1:0]      if_rdata;
  // Data port
  logic                       dm_req;
  logic                       dm_we;
  logic [ADDRESS_WIDTH-1:0]   dm_addr;
  logic [DATA_WIDTH-1:0]      dm_wdata;
  logic [DATA_WIDTH/8-1:0]    dm_be;
  logic                       dm_ack;
  logic [DATA_WIDTH-1:0]      dm_rdata;
  // Memory port
  logic                       mem_req;
  logic                       mem_we;
  logic [ADDRESS_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [DATA_WIDTH/8-1:0]    mem_be;
  logic                       mem_ack;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_ctr
// Description : Saturating count of data grants issued while fetch waits.
//               at_limit forces the next arbitration in favour of fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,       // asynchronous, active low
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int               CNT_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] r_count;

  // Clear wins over increment; increment saturates at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign at_limit = (r_count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between instruction fetch and
//               data access. Data has priority; a starvation counter forces a
//               fetch grant after STARVE_LIMIT data grants made while fetch
//               was waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,          // asynchronous, active low
  mem_port_arbiter_if.master   bus,
  output logic                 stall_f,
  output logic                 stall_m,
  output logic [1:0]           owner,
  output logic                 err_spurious
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  state_e                     r_state;
  state_e                     w_state_next;
  logic                       r_mem_req;
  logic                       r_mem_we;
  logic [ADDRESS_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]      r_mem_wdata;
  logic [BE_WIDTH-1:0]        r_mem_be;
  logic                       r_if_ack;
  logic                       r_dm_ack;
  logic [DATA_WIDTH-1:0]      r_if_rdata;
  logic [DATA_WIDTH-1:0]      r_dm_rdata;
  logic                       r_err;

  logic w_if_req_m;
  logic w_dm_req_m;
  logic w_turnaround;
  logic w_at_limit;
  logic w_grant_i;
  logic w_grant_d;
  logic w_done_i;
  logic w_done_d;
  logic w_ctr_inc;
  logic w_ctr_clr;

  // A requester being acked this cycle has not yet had the chance to drop
  // or renew its request, so its stale req is masked out.
  assign w_if_req_m = bus.if_req & ~r_if_ack;
  assign w_dm_req_m = bus.dm_req & ~r_dm_ack;

  // The ack cycle is the single idle cycle between transactions and carries
  // no grant. This lets a just-acked data requester renew before the next
  // arbitration, which is what makes data priority and the starvation limit
  // observable against a continuously waiting fetch.
  assign w_turnaround = r_if_ack | r_dm_ack;

  assign w_done_i = (r_state == S_BUSY_I) & bus.mem_ack;
  assign w_done_d = (r_state == S_BUSY_D) & bus.mem_ack;

  // Starve count tracks data grants taken while fetch was waiting
  assign w_ctr_inc = w_grant_d & w_if_req_m;
  assign w_ctr_clr = w_grant_i | ((r_state == S_IDLE) & ~bus.if_req);

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_ctr_inc),
    .clr      (w_ctr_clr),
    .at_limit (w_at_limit)
  );

  // Next-state and grant decision
  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_turnaround) begin
          if (w_dm_req_m && !(w_if_req_m && w_at_limit)) begin
            w_grant_d    = 1'b1;
            w_state_next = S_BUSY_D;
          end else if (w_if_req_m) begin
            w_grant_i    = 1'b1;
            w_state_next = S_BUSY_I;
          end
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (bus.mem_ack) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Memory request: latched on grant, held until mem_ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else if (w_grant_d) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= bus.dm_we;
      r_mem_addr  <= bus.dm_addr;
      r_mem_wdata <= bus.dm_wdata;
      r_mem_be    <= bus.dm_be;
    end else if (w_grant_i) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= bus.if_addr;
      r_mem_wdata <= '0;
      r_mem_be    <= '1;
    end else if (w_done_i || w_done_d) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Completion: one-cycle ack pulse and owner's read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_ack   <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_if_ack <= w_done_i;
      r_dm_ack <= w_done_d;
      if (w_done_i) r_if_rdata <= bus.mem_rdata;
      if (w_done_d) r_dm_rdata <= bus.mem_rdata;
    end
  end

  // Sticky flag for a memory ack arriving with nothing outstanding
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.mem_ack) begin
      r_err <= 1'b1;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.if_ack    = r_if_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.dm_rdata  = r_dm_rdata;

  assign stall_f      = bus.if_req & ~r_if_ack;
  assign stall_m      = bus.dm_req & ~r_dm_ack;
  assign owner        = owner_of(r_state);
  assign err_spurious = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: per-cycle vector
//               table for fetch-only and contention traffic, plus directed
//               sequences for store wait states, starvation, async reset and
//               spurious acks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall_f;
  logic       stall_m;
  logic [1:0] owner;
  logic       err_spurious;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

  mem_port_arbiter #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .STARVE_LIMIT  (3)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .stall_f      (stall_f),
    .stall_m      (stall_m),
    .owner        (owner),
    .err_spurious (err_spurious)
  );

  // 10-unit clock; inputs change and outputs are sampled on the falling edge
  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        e_if_ack;
    logic        e_dm_ack;
    logic [31:0] e_if_rdata;
    logic [31:0] e_dm_rdata;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [3:0]  e_mem_be;
    logic        e_stall_f;
    logic        e_stall_m;
    logic [1:0]  e_owner;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_quiet();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.dm_be     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  function automatic logic [63:0] cnt();
    return 64'(u_dut.u_starve.r_count);
  endfunction

  // Watchdog: every sequence is cycle-exact, this only guards against a hang
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                if   if_addr      dm we dm_addr      dm_wdata  be    ack rdata        | iack dack if_rdata      dm_rdata      mreq mwe maddr        mbe   sf   sm   owner
    // fetch only: grant, mem ack one cycle after mem_req, if_ack in cycle 3
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,    4'h0, 1'b1, 1'b0, OWNER_IDLE};
    vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h100,  4'hF, 1'b1, 1'b0, OWNER_FETCH};
    vecs[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0, 4'h0, 1'b1, 32'h00500093, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h100,  4'hF, 1'b1, 1'b0, OWNER_FETCH};
    vecs[3]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0, 4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00500093, 32'h0,        1'b0, 1'b0, 32'h100,  4'hF, 1'b0, 1'b0, OWNER_IDLE};
    vecs[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00500093, 32'h0,        1'b0, 1'b0, 32'h100,  4'hF, 1'b0, 1'b0, OWNER_IDLE};
    // contention: data load wins, one idle turnaround, then fetch
    vecs[5]  = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00500093, 32'h0,        1'b0, 1'b0, 32'h100,  4'hF, 1'b1, 1'b1, OWNER_IDLE};
    vecs[6]  = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b1, 32'h11112222, 1'b0, 1'b0, 32'h00500093, 32'h0,        1'b1, 1'b0, 32'h2000, 4'hF, 1'b1, 1'b1, OWNER_DATA};
    vecs[7]  = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00500093, 32'h11112222, 1'b0, 1'b0, 32'h2000, 4'hF, 1'b1, 1'b0, OWNER_IDLE};
    vecs[8]  = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00500093, 32'h11112222, 1'b0, 1'b0, 32'h2000, 4'hF, 1'b1, 1'b0, OWNER_IDLE};
    vecs[9]  = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b1, 32'hAAAA5555, 1'b0, 1'b0, 32'h00500093, 32'h11112222, 1'b1, 1'b0, 32'h104,  4'hF, 1'b1, 1'b0, OWNER_FETCH};
    vecs[10] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 32'hAAAA5555, 32'h11112222, 1'b0, 1'b0, 32'h104,  4'hF, 1'b0, 1'b0, OWNER_IDLE};
    vecs[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'hAAAA5555, 32'h11112222, 1'b0, 1'b0, 32'h104,  4'hF, 1'b0, 1'b0, OWNER_IDLE};

    // ---------------- reset state ----------------
    drive_quiet();
    @(negedge clk); #1;
    chk("rst.mem_req",  64'(bus.mem_req),  64'd0);
    chk("rst.mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst.mem_be",   64'(bus.mem_be),   64'd0);
    chk("rst.if_ack",   64'(bus.if_ack),   64'd0);
    chk("rst.dm_ack",   64'(bus.dm_ack),   64'd0);
    chk("rst.if_rdata", 64'(bus.if_rdata), 64'd0);
    chk("rst.dm_rdata", 64'(bus.dm_rdata), 64'd0);
    chk("rst.owner",    64'(owner),        64'(OWNER_IDLE));
    chk("rst.err",      64'(err_spurious), 64'd0);
    chk("rst.cnt",      cnt(),             64'd0);
    @(negedge clk); rst = 1'b1;

    // ---------------- vector table ----------------
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.if_req    = vecs[i].if_req;
      bus.if_addr   = vecs[i].if_addr;
      bus.dm_req    = vecs[i].dm_req;
      bus.dm_we     = vecs[i].dm_we;
      bus.dm_addr   = vecs[i].dm_addr;
      bus.dm_wdata  = vecs[i].dm_wdata;
      bus.dm_be     = vecs[i].dm_be;
      bus.mem_ack   = vecs[i].mem_ack;
      bus.mem_rdata = vecs[i].mem_rdata;
      #1;
      chk($sformatf("v%0d.if_ack", i),   64'(bus.if_ack),   64'(vecs[i].e_if_ack));
      chk($sformatf("v%0d.dm_ack", i),   64'(bus.dm_ack),   64'(vecs[i].e_dm_ack));
      chk($sformatf("v%0d.if_rdata", i), 64'(bus.if_rdata), 64'(vecs[i].e_if_rdata));
      chk($sformatf("v%0d.dm_rdata", i), 64'(bus.dm_rdata), 64'(vecs[i].e_dm_rdata));
      chk($sformatf("v%0d.mem_req", i),  64'(bus.mem_req),  64'(vecs[i].e_mem_req));
      chk($sformatf("v%0d.mem_we", i),   64'(bus.mem_we),   64'(vecs[i].e_mem_we));
      chk($sformatf("v%0d.mem_addr", i), 64'(bus.mem_addr), 64'(vecs[i].e_mem_addr));
      chk($sformatf("v%0d.mem_be", i),   64'(bus.mem_be),   64'(vecs[i].e_mem_be));
      chk($sformatf("v%0d.stall_f", i),  64'(stall_f),      64'(vecs[i].e_stall_f));
      chk($sformatf("v%0d.stall_m", i),  64'(stall_m),      64'(vecs[i].e_stall_m));
      chk($sformatf("v%0d.owner", i),    64'(owner),        64'(vecs[i].e_owner));
    end

    // ---------------- store with five wait states ----------------
    @(negedge clk);
    drive_quiet();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h2004;
    bus.dm_wdata = 32'hDEADBEEF; bus.dm_be = 4'b0011;
    #1;
    chk("st.owner0", 64'(owner),   64'(OWNER_IDLE));
    chk("st.stall_m", 64'(stall_m), 64'd1);
    @(negedge clk); #1;
    chk("st.owner",    64'(owner),         64'(OWNER_DATA));
    chk("st.mem_addr", 64'(bus.mem_addr),  64'h2004);
    for (int w = 0; w < 5; w++) begin
      @(negedge clk); #1;
      chk($sformatf("st.w%0d.mem_req", w),   64'(bus.mem_req),   64'd1);
      chk($sformatf("st.w%0d.mem_we", w),    64'(bus.mem_we),    64'd1);
      chk($sformatf("st.w%0d.mem_be", w),    64'(bus.mem_be),    64'h3);
      chk($sformatf("st.w%0d.mem_wdata", w), 64'(bus.mem_wdata), 64'hDEADBEEF);
      chk($sformatf("st.w%0d.dm_ack", w),    64'(bus.dm_ack),    64'd0);
    end
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1;
    chk("st.ackcyc.mem_req", 64'(bus.mem_req), 64'd1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("st.dm_ack",   64'(bus.dm_ack),  64'd1);
    chk("st.stall_m1", 64'(stall_m),     64'd0);
    chk("st.mem_req",  64'(bus.mem_req), 64'd0);
    @(negedge clk);
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    #1;
    chk("st.dm_ack_pulse", 64'(bus.dm_ack), 64'd0);

    // ---------------- starvation: fetch forced after 3 data grants ----------------
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2100; bus.dm_be = 4'hF;
    #1;
    chk("sv.owner0", 64'(owner), 64'(OWNER_IDLE));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("sv.g%0d.owner", k),    64'(owner),        64'(OWNER_DATA));
      chk($sformatf("sv.g%0d.mem_addr", k), 64'(bus.mem_addr), 64'(32'h2100 + 32'(4 * k)));
      chk($sformatf("sv.g%0d.cnt", k),      cnt(),             64'(k + 1));
      chk($sformatf("sv.g%0d.stall_f", k),  64'(stall_f),      64'd1);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'(k);
      @(negedge clk);
      bus.mem_ack = 1'b0; bus.dm_addr = 32'h2100 + 32'(4 * (k + 1));
      #1;
      chk($sformatf("sv.g%0d.dm_ack", k), 64'(bus.dm_ack), 64'd1);
      chk($sformatf("sv.g%0d.if_ack", k), 64'(bus.if_ack), 64'd0);
      @(negedge clk); #1;
      chk($sformatf("sv.g%0d.idle", k), 64'(owner), 64'(OWNER_IDLE));
    end
    @(negedge clk); #1;
    chk("sv.forced.owner",    64'(owner),        64'(OWNER_FETCH));
    chk("sv.forced.mem_addr", 64'(bus.mem_addr), 64'h300);
    chk("sv.forced.cnt",      cnt(),             64'd0);
    chk("sv.forced.stall_m",  64'(stall_m),      64'd1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00000013;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("sv.if_ack",   64'(bus.if_ack),   64'd1);
    chk("sv.if_rdata", 64'(bus.if_rdata), 64'h13);
    @(negedge clk);
    bus.if_req = 1'b0;
    #1;
    chk("sv.turn", 64'(owner), 64'(OWNER_IDLE));
    @(negedge clk); #1;
    chk("sv.data_again",  64'(owner),        64'(OWNER_DATA));
    chk("sv.data_addr",   64'(bus.mem_addr), 64'h210C);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5A5A0000;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("sv.last.dm_ack",   64'(bus.dm_ack),   64'd1);
    chk("sv.last.dm_rdata", 64'(bus.dm_rdata), 64'h5A5A0000);
    @(negedge clk);
    bus.dm_req = 1'b0;

    // ---------------- spurious memory ack ----------------
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1;
    chk("sp.err_before", 64'(err_spurious), 64'd0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("sp.err",      64'(err_spurious), 64'd1);
    chk("sp.if_ack",   64'(bus.if_ack),   64'd0);
    chk("sp.dm_ack",   64'(bus.dm_ack),   64'd0);
    chk("sp.dm_rdata", 64'(bus.dm_rdata), 64'h5A5A0000);
    chk("sp.owner",    64'(owner),        64'(OWNER_IDLE));
    repeat (3) @(negedge clk);
    #1;
    chk("sp.sticky", 64'(err_spurious), 64'd1);

    // ---------------- asynchronous reset during a data transaction ----------------
    @(negedge clk);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2200; bus.dm_be = 4'hF;
    @(negedge clk); #1;
    chk("ar.busy",    64'(owner),       64'(OWNER_DATA));
    chk("ar.mem_req", 64'(bus.mem_req), 64'd1);
    #2;
    rst = 1'b0;
    bus.dm_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h400;
    #1;
    chk("ar.mem_req0",  64'(bus.mem_req),  64'd0);
    chk("ar.owner0",    64'(owner),        64'(OWNER_IDLE));
    chk("ar.dm_ack0",   64'(bus.dm_ack),   64'd0);
    chk("ar.if_ack0",   64'(bus.if_ack),   64'd0);
    chk("ar.cnt0",      cnt(),             64'd0);
    chk("ar.err0",      64'(err_spurious), 64'd0);
    chk("ar.mem_addr0", 64'(bus.mem_addr), 64'd0);
    chk("ar.if_rdata0", 64'(bus.if_rdata), 64'd0);
    @(negedge clk); #1;
    chk("ar.held", 64'(owner), 64'(OWNER_IDLE));
    rst = 1'b1;
    @(negedge clk); #1;
    chk("ar.fetch.owner", 64'(owner),        64'(OWNER_FETCH));
    chk("ar.fetch.addr",  64'(bus.mem_addr), 64'h400);
    chk("ar.fetch.we",    64'(bus.mem_we),   64'd0);
    chk("ar.fetch.be",    64'(bus.mem_be),   64'hF);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE0001;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("ar.fetch.if_ack", 64'(bus.if_ack),   64'd1);
    chk("ar.fetch.rdata",  64'(bus.if_rdata), 64'hCAFE0001);
    chk("ar.fetch.err",    64'(err_spurious), 64'd0);
    @(negedge clk);
    bus.if_req = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Data requests have priority over fetch; a starvation counter guarantees fetch forward progress.
- Drives `stall_f` and `stall_m` into the pipeline registers and hazard logic.
- Memory side uses a req/ack handshake with variable latency.

Parameters:
- `DATA_WIDTH`, 32, memory word width.
- `ADDRESS_WIDTH`, 32, byte address width.
- `STARVE_LIMIT`, 3, consecutive data grants allowed while fetch waits before fetch is forced.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `if_req` input 1: fetch read request; held until `if_ack`.
- `if_addr` input `ADDRESS_WIDTH`: fetch address.
- `if_ack` output 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` output `DATA_WIDTH`: registered instruction word.
- `dm_req` input 1: data request; held until `dm_ack`.
- `dm_we` input 1: 1 = store.
- `dm_addr` input `ADDRESS_WIDTH`: data address.
- `dm_wdata` input `DATA_WIDTH`: store data.
- `dm_be` input `DATA_WIDTH/8`: byte enables.
- `dm_ack` output 1: one-cycle pulse; `dm_rdata` valid for loads.
- `dm_rdata` output `DATA_WIDTH`: registered load data.
- `mem_req` output 1: memory request, registered.
- `mem_we` output 1: memory write enable.
- `mem_addr` output `ADDRESS_WIDTH`: latched address.
- `mem_wdata` output `DATA_WIDTH`: latched write data.
- `mem_be` output `DATA_WIDTH/8`: latched byte enables (all ones for fetch).
- `mem_ack` input 1: memory completion, one cycle.
- `mem_rdata` input `DATA_WIDTH`: valid with `mem_ack`.
- `stall_f` output 1: `if_req & ~if_ack`, combinational.
- `stall_m` output 1: `dm_req & ~dm_ack`, combinational.
- `owner` output 2: 00 idle, 01 fetch, 10 data.
- `err_spurious` output 1: sticky; set on `mem_ack` with no outstanding request.

Behaviour:
- Reset (`rst`=0, async): state IDLE, starve count 0.
  - All outputs 0, including `if_rdata`, `dm_rdata`, `err_spurious`.
  - In-flight transaction is abandoned; memory treats `mem_req` low as abort.
- States: IDLE, BUSY_I, BUSY_D.
- Masking: in any cycle where `if_ack` (`dm_ack`) is high, that requester's req is ignored by arbitration. The requester drops or renews req after the ack edge.
- IDLE arbitration (with masked reqs):
  - If `dm_req` and not (`if_req` and count==`STARVE_LIMIT`): grant data, go to BUSY_D.
  - Else if `if_req`: grant fetch, go to BUSY_I.
  - Else stay IDLE.
- On grant edge:
  - `mem_req`=1; `mem_addr`/`mem_wdata`/`mem_we`/`mem_be` latched from the winner.
  - Fetch grant forces `mem_we`=0 and `mem_be`=all ones.
- BUSY_x: `mem_*` held stable until `mem_ack`.
- On `mem_ack` edge:
  - `mem_req`=0 and state returns to IDLE.
  - Owner's `rdata` register is loaded from `mem_rdata`; it is loaded for stores too, value don't-care.
  - Owner's ack is pulsed high for exactly one cycle.
- Latency and throughput:
  - Minimum request-to-ack is 3 cycles: grant edge, `mem_ack` at earliest the next cycle, ack edge.
  - No new grant is issued in the same edge as completion; one idle-state cycle occurs between transactions.
- Starve counter:
  - Increments (saturating at `STARVE_LIMIT`) on every data grant while `if_req` is unmasked-high.
  - Clears on every fetch grant.
  - Also clears when `if_req` is low in IDLE.
- Ack persistence: `if_rdata`/`dm_rdata` hold their last value until the next ack for that requester.
- `owner` reflects state combinationally.
- `mem_ack` in IDLE is ignored for data and sets `err_spurious`, which clears only on reset.
- Simultaneous `if_req` and `dm_req` from IDLE with count<LIMIT: data wins.

Decomposition:
- Shared package (cpu pkg): state encoding localparams (IDLE/BUSY_I/BUSY_D) and `owner` codes.
- One sub-module: `arb_starve_ctr` (saturating counter with inc/clr/at_limit), parameterised by `STARVE_LIMIT`.

Test Plan:
- Fetch only: `if_req`=1, `if_addr`=0x100, memory acks 1 cycle after `mem_req` → `mem_addr`=0x100, `mem_we`=0, `if_ack` pulse at cycle 3, `if_rdata`=0x00500093, `stall_f` high cycles 0-2.
- Contention: `if_req` and `dm_req` (load 0x2000) both asserted in cycle 0 → data granted first, `stall_f`=1 until data completes, then fetch granted; `owner` sequence 10,00,01.
- Starvation: `if_req` held, `dm_req` reissued after every `dm_ack`, `STARVE_LIMIT`=3 → exactly 3 data grants, then fetch granted despite pending `dm_req`; count returns to 0.
- Store: `dm_we`=1, `dm_addr`=0x2004, `dm_wdata`=0xDEADBEEF, `dm_be`=0011 → `mem_we`=1, `mem_be`=0011, `mem_wdata` stable until `mem_ack` inserted after 5 wait cycles; `dm_ack` one cycle.
- Reset mid-transaction: `rst` low while BUSY_D → `mem_req`, `owner`, acks and count go to 0 immediately (async); after release, pending `if_req` is granted normally.
- Spurious ack: pulse `mem_ack` in IDLE → `err_spurious`=1 and stays 1; no `if_ack`/`dm_ack`; cleared only by `rst`.
